// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - two-way intersection phase scheduler; PED_WALK_EN adds pedestrian walk phase
module traffic_phase_scheduler #(
  parameter int TICK_DIV     = 100000000,
  parameter int GREEN_TICKS  = 5,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1,
  parameter int WALK_TICKS   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ped_req,
  output logic       ped_ack,
  output logic [2:0] light_ns,
  output logic [2:0] light_ew,
  output logic       walk,
  output logic [2:0] phase
);

  // Phase state codes; the code is also exported on the debug phase port.
  localparam logic [2:0] S_ALLRED_A  = 3'd0;
  localparam logic [2:0] S_NS_GREEN  = 3'd1;
  localparam logic [2:0] S_NS_YELLOW = 3'd2;
  localparam logic [2:0] S_ALLRED_B  = 3'd3;
  localparam logic [2:0] S_EW_GREEN  = 3'd4;
  localparam logic [2:0] S_EW_YELLOW = 3'd5;
  localparam logic [2:0] S_WALK      = 3'd6;

  // One-hot lamp encodings.
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_GREEN  = 3'b010;
  localparam logic [2:0] LAMP_YELLOW = 3'b001;

  // Terminal values: a state ends on the tick where the timer equals duration-1.
  localparam logic [27:0] LP_TICK_LAST   = 28'(TICK_DIV - 1);
  localparam logic [3:0]  LP_GREEN_LAST  = 4'(GREEN_TICKS - 1);
  localparam logic [3:0]  LP_YELLOW_LAST = 4'(YELLOW_TICKS - 1);
  localparam logic [3:0]  LP_ALLRED_LAST = 4'(ALLRED_TICKS - 1);
  localparam logic [3:0]  LP_WALK_LAST   = 4'(WALK_TICKS - 1);

  logic [2:0]  r_state;
  logic [27:0] r_presc;
  logic [3:0]  r_timer;
  logic        r_ped_ack;
  logic [2:0]  r_light_ns;
  logic [2:0]  r_light_ew;
  logic        r_walk;
  logic [2:0]  r_phase;

  logic        w_tick;
  logic [3:0]  w_dur_last;
  logic        w_phase_done;
  logic [2:0]  w_next_state;
  logic        w_state_change;
  logic        w_enter_walk;
  logic [2:0]  w_light_ns;
  logic [2:0]  w_light_ew;
  logic        w_walk;

`ifdef PED_WALK_EN
  logic        r_ped_pending;
`else
  logic        w_unused_ped_req;
  assign w_unused_ped_req = ped_req;
`endif

  // Tick is decoded from the registered count, so it is a clean one-cycle strobe.
  assign w_tick         = (r_presc == LP_TICK_LAST);
  assign w_phase_done   = w_tick && (r_timer == w_dur_last);
  assign w_state_change = (w_next_state != r_state);

  // Free-running prescaler, wrapping at TICK_DIV-1; first tick lands TICK_DIV clocks after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc <= 28'd0;
    end else if (w_tick) begin
      r_presc <= 28'd0;
    end else begin
      r_presc <= r_presc + 28'd1;
    end
  end

  // Phase timer counts ticks spent in the current state and restarts on every state change.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_timer <= 4'd0;
    end else if (w_state_change) begin
      r_timer <= 4'd0;
    end else if (w_tick) begin
      r_timer <= r_timer + 4'd1;
    end
  end

  // Select the terminal timer value for the state currently being timed.
  always_comb begin
    w_dur_last = LP_ALLRED_LAST;
    case (r_state)
      S_NS_GREEN, S_EW_GREEN:   w_dur_last = LP_GREEN_LAST;
      S_NS_YELLOW, S_EW_YELLOW: w_dur_last = LP_YELLOW_LAST;
      S_WALK:                   w_dur_last = LP_WALK_LAST;
      default:                  w_dur_last = LP_ALLRED_LAST;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_ALLRED_A;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; any unused code falls back to ALLRED_A immediately.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_ALLRED_A:  if (w_phase_done) w_next_state = S_NS_GREEN;
      S_NS_GREEN:  if (w_phase_done) w_next_state = S_NS_YELLOW;
      S_NS_YELLOW: if (w_phase_done) w_next_state = S_ALLRED_B;
      S_ALLRED_B:  if (w_phase_done) w_next_state = S_EW_GREEN;
      S_EW_GREEN:  if (w_phase_done) w_next_state = S_EW_YELLOW;
`ifdef PED_WALK_EN
      S_EW_YELLOW: if (w_phase_done) w_next_state = r_ped_pending ? S_WALK : S_ALLRED_A;
      S_WALK:      if (w_phase_done) w_next_state = S_ALLRED_A;
`else
      S_EW_YELLOW: if (w_phase_done) w_next_state = S_ALLRED_A;
`endif
      default:     w_next_state = S_ALLRED_A;
    endcase
  end

  // FSM output decode from the next state, so registered lamps change on the same edge as the state.
  always_comb begin
    w_light_ns = LAMP_RED;
    w_light_ew = LAMP_RED;
    w_walk     = 1'b0;
    case (w_next_state)
      S_NS_GREEN:  w_light_ns = LAMP_GREEN;
      S_NS_YELLOW: w_light_ns = LAMP_YELLOW;
      S_EW_GREEN:  w_light_ew = LAMP_GREEN;
      S_EW_YELLOW: w_light_ew = LAMP_YELLOW;
`ifdef PED_WALK_EN
      S_WALK:      w_walk     = 1'b1;
`endif
      default: begin
        w_light_ns = LAMP_RED;
        w_light_ew = LAMP_RED;
      end
    endcase
  end

`ifdef PED_WALK_EN
  assign w_enter_walk = (r_state == S_EW_YELLOW) && (w_next_state == S_WALK);

  // Latch a pedestrian request; consuming it on WALK entry wins over a same-cycle request.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ped_pending <= 1'b0;
    end else if (w_enter_walk) begin
      r_ped_pending <= 1'b0;
    end else if (ped_req && (r_state != S_WALK)) begin
      r_ped_pending <= 1'b1;
    end
  end
`else
  assign w_enter_walk = 1'b0;
`endif

  // Output registers; reset forces all-red immediately, abandoning any phase in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_light_ns <= LAMP_RED;
      r_light_ew <= LAMP_RED;
      r_walk     <= 1'b0;
      r_ped_ack  <= 1'b0;
      r_phase    <= S_ALLRED_A;
    end else begin
      r_light_ns <= w_light_ns;
      r_light_ew <= w_light_ew;
      r_walk     <= w_walk;
      r_ped_ack  <= w_enter_walk;
      r_phase    <= w_next_state;
    end
  end

  assign light_ns = r_light_ns;
  assign light_ew = r_light_ew;
  assign walk     = r_walk;
  assign ped_ack  = r_ped_ack;
  assign phase    = r_phase;

endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 100000000: clocks per phase tick (1 s at 100 MHz); legal range 2..2^28-1.
REQ-002 SHALL provide parameter GREEN_TICKS, default 5: green duration in ticks; legal range 1..15.
REQ-003 SHALL provide parameter YELLOW_TICKS, default 2: yellow duration in ticks; legal range 1..15.
REQ-004 SHALL provide parameter ALLRED_TICKS, default 1: all-red clearance duration in ticks; legal range 1..15.
REQ-005 SHALL provide parameter WALK_TICKS, default 4: pedestrian walk duration in ticks; legal range 1..15.
REQ-006 SHALL have port: clock  input  1  sole clock, rising edge.
REQ-007 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port: ped_req  input  1  pedestrian request; a single-cycle pulse or a held level.
REQ-009 SHALL have port: ped_ack  output  1  one-cycle pulse on entry to WALK.
REQ-010 SHALL have port: light_ns  output  3  north-south lamp; RED=100, GREEN=010, YELLOW=001.
REQ-011 SHALL have port: light_ew  output  3  east-west lamp; same encoding as light_ns.
REQ-012 SHALL have port: walk  output  1  pedestrian walk lamp.
REQ-013 SHALL have port: phase  output  3  current state code, for debug.

Function
REQ-014 SHALL use a 28-bit prescaler counting 0..TICK_DIV-1 and wrapping; internal tick SHALL be high for exactly the one cycle in which count==TICK_DIV-1.
REQ-015 SHALL use a 4-bit phase timer, advanced only on tick, cleared on every state change.
REQ-016 SHALL leave a state on the tick where phase timer==duration-1, so each state lasts exactly duration×TICK_DIV clocks.
REQ-017 SHALL implement these states and codes: ALLRED_A=0, NS_GREEN=1, NS_YELLOW=2, ALLRED_B=3, EW_GREEN=4, EW_YELLOW=5, WALK=6.
REQ-018 SHALL sequence states ALLRED_A->NS_GREEN->NS_YELLOW->ALLRED_B->EW_GREEN->EW_YELLOW->(WALK if ped_pending, else ALLRED_A); WALK->ALLRED_A.
REQ-019 SHALL drive lamps per state:
- NS_GREEN/NS_YELLOW: light_ns=GREEN/YELLOW, light_ew=RED.
- EW_GREEN/EW_YELLOW: light_ew=GREEN/YELLOW, light_ns=RED.
- All other states: both lamps RED.
REQ-020 SHALL drive walk=1 only in WALK; both lamps SHALL be RED whenever walk=1.
REQ-021 SHALL set ped_pending on any cycle with ped_req=1 while not in WALK; ped_req during WALK SHALL be ignored.
REQ-022 SHALL clear ped_pending and pulse ped_ack on the EW_YELLOW->WALK transition edge; ped_req on that same cycle SHALL NOT re-set ped_pending.
REQ-023 SHALL register all outputs, updating on the same edge as the state change, with no combinational path from ped_req to any output.
REQ-024 SHALL never produce a GREEN or YELLOW lamp on both directions at once; illegal state codes SHALL recover to ALLRED_A on the next clock.

Reset
REQ-025 SHALL, while reset=1 at a clock edge, set state=ALLRED_A, prescaler=0, phase timer=0, ped_pending=0, light_ns=light_ew=RED, walk=0, ped_ack=0, phase=0.
REQ-026 SHALL abandon any phase immediately on reset asserted mid-operation, with no yellow completion.
REQ-027 SHALL place the first tick TICK_DIV clocks after reset deasserts.

Configuration
REQ-028 SHALL, with macro PED_WALK_EN defined, implement ped_pending, WALK, walk and ped_ack as above.
REQ-029 SHALL, without PED_WALK_EN, retain ports ped_req, ped_ack and walk; walk and ped_ack SHALL be tied 0, ped_req ignored, WALK removed, and EW_YELLOW SHALL always go to ALLRED_A.

Verification (TICK_DIV=4, GREEN=3, YELLOW=2, ALLRED=1, WALK=2)
REQ-030 Reset release, no requests -> both RED for 4 clocks; NS GREEN 12, NS YELLOW 8, RED/RED 4, EW GREEN 12, EW YELLOW 8; repeats with a 48-clock period.
REQ-031 One-cycle ped_req during NS_GREEN with PED_WALK_EN -> after EW_YELLOW, walk=1 for 8 clocks with both RED, ped_ack high 1 cycle at WALK entry, then ALLRED_A; period 56.
REQ-032 ped_req held high across the WALK-entry edge and through WALK -> exactly one WALK, and the following cycle has no WALK unless ped_req recurs after WALK exits.
REQ-033 reset asserted for 1 clock mid EW_GREEN -> next clock both RED, phase=0, ped_pending cleared, timing restarts per REQ-030.
REQ-034 PED_WALK_EN undefined, ped_req pulsed every 10 clocks -> walk=0 and ped_ack=0 throughout; period 48; the both-non-RED check passes every cycle.
